peripheral_dsa_scheduler: RTL

Round-robin scheduler that shares one DSA processing unit (DATA_SIZE-wide operand/result datapath) between N_REQ requesters inside the peripheral. It accepts one request at a time, drives the unit's start/operand handshake, and waits for the unit's ready with a watchdog timeout. It then returns the result or an error pulse to the granted requester. Sits between the MPSoC-side requester ports and the single shared DSA datapath.

---
 rtl/peripheral_dsa_scheduler_if.sv | 28 ++
 rtl/peripheral_dsa_scheduler.sv | 116 +++++++++++
 2 files changed

// File: rtl/peripheral_dsa_scheduler_if.sv
// Requester-side and shared-unit-side signals of the DSA scheduler.
// The scheduler takes the slave view; the environment takes the master view.
interface peripheral_dsa_scheduler_if #(
  parameter int DATA_SIZE = 512,
  parameter int N_REQ     = 4
);
  logic [N_REQ-1:0]           req;
  logic [N_REQ*DATA_SIZE-1:0] req_data;
  logic [N_REQ-1:0]           grant;
  logic [N_REQ-1:0]           done;
  logic [N_REQ-1:0]           error;
  logic [DATA_SIZE-1:0]       result;
  logic                       busy;
  logic                       unit_start;
  logic [DATA_SIZE-1:0]       unit_data_in;
  logic                       unit_ready;
  logic [DATA_SIZE-1:0]       unit_data_out;

  modport slave (
    input  req, req_data, unit_ready, unit_data_out,
    output grant, done, error, result, busy, unit_start, unit_data_in
  );

  modport master (
    output req, req_data, unit_ready, unit_data_out,
    input  grant, done, error, result, busy, unit_start, unit_data_in
  );
endinterface

// File: rtl/peripheral_dsa_scheduler.sv
// Round-robin owner of one shared DSA unit: grant, start, wait with watchdog,
// then pulse DONE or ERROR to the granted requester.
module peripheral_dsa_scheduler #(
  parameter int DATA_SIZE = 512,
  parameter int N_REQ     = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  peripheral_dsa_scheduler_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

  state_t state, nxt;

  logic [N_REQ-1:0][DATA_SIZE-1:0] req_arr;
  logic [IW-1:0]        ptr, idx, sel;
  logic [IW:0]          cand;
  logic                 found;
  logic [CW-1:0]        cnt;
  logic                 expire;
  logic [N_REQ-1:0]     grant_r, done_r, error_r;
  logic [DATA_SIZE-1:0] result_r, unit_data_r;
  logic                 busy_r, start_r;

  assign req_arr = bus.req_data;
  assign expire  = (TIMEOUT != 0) && (cnt == TLAST);

  // Scan offsets high to low so the nearest set bit at or above ptr wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (bus.req[cand[IW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (found) nxt = S_ISSUE;
      S_ISSUE:  nxt = S_WAIT;
      S_WAIT:   if (bus.unit_ready || expire) nxt = S_RETURN;
      S_RETURN: nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      idx         <= '0;
      cnt         <= '0;
      grant_r     <= '0;
      done_r      <= '0;
      error_r     <= '0;
      result_r    <= '0;
      unit_data_r <= '0;
      busy_r      <= 1'b0;
      start_r     <= 1'b0;
    end else begin
      start_r <= 1'b0;
      done_r  <= '0;
      error_r <= '0;
      case (state)
        S_IDLE: if (found) begin
          idx         <= sel;
          grant_r     <= N_REQ'(1) << sel;
          unit_data_r <= req_arr[sel];
          start_r     <= 1'b1;
          busy_r      <= 1'b1;
        end
        S_ISSUE: cnt <= '0;
        // A ready strobe on the expiry cycle still counts as success.
        S_WAIT: begin
          if (bus.unit_ready) begin
            result_r    <= bus.unit_data_out;
            done_r[idx] <= 1'b1;
          end else if (expire) begin
            error_r[idx] <= 1'b1;
          end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RETURN: begin
          ptr     <= (idx == IW'(N_REQ - 1)) ? '0 : idx + 1'b1;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant        = grant_r;
  assign bus.done         = done_r;
  assign bus.error        = error_r;
  assign bus.result       = result_r;
  assign bus.busy         = busy_r;
  assign bus.unit_start   = start_r;
  assign bus.unit_data_in = unit_data_r;
endmodule
